// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared constants and control decode for the EX/MEM pipeline register.
// Replaces the old defines.vh macros with typed package items.
package ex_mem_stage_reg_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam int   STALL_W       = 6;

    typedef enum logic [1:0] {
        CTL_ADVANCE = 2'd0,
        CTL_BUBBLE  = 2'd1,
        CTL_HOLD    = 2'd2,
        CTL_FLUSH   = 2'd3
    } stage_ctl_e;

    // Flush wins over any stall pattern; advance and bubble/hold are exclusive.
    function automatic stage_ctl_e decode_ctl(input logic flush, input logic held,
                                              input logic next_held);
        if (flush)
            return CTL_FLUSH;
        else if (held == NO_STOP)
            return CTL_ADVANCE;
        else if (next_held == NO_STOP)
            return CTL_BUBBLE;
        else
            return CTL_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_stage_reg_pipe_lane_reg.sv
// One register-write lane of the EX/MEM register: {wd, wreg, wdata}.
// Clear and bubble both load a NOP; without advance or bubble the lane holds.
module pipe_lane_reg
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic                  bubble,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o
);

    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (clear || bubble) begin
            wd_d    = '0;
            wreg_d  = WRITE_DISABLE;
            wdata_d = '0;
        end else if (advance) begin
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wd_q    <= '0;
            wreg_q  <= WRITE_DISABLE;
            wdata_q <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign wd_o    = wd_q;
    assign wreg_o  = wreg_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: N write lanes, load/store operands, MADD/MSUB
// temporaries carried across stalls, valid flag and saturating bubble counter.
module ex_mem_stage_reg
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int REG_ADDR_W  = 5,
    parameter int DATA_W      = 32,
    parameter int ALUOP_W     = 8,
    parameter int CNT_W       = 2,
    parameter int STAGE       = 3,
    parameter int STALL_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STALL_W-1:0]          stall,
    input  logic                        flush,
    input  logic [LANES*REG_ADDR_W-1:0] ex_wd,
    input  logic [LANES-1:0]            ex_wreg,
    input  logic [LANES*DATA_W-1:0]     ex_wdata,
    input  logic                        ex_whilo,
    input  logic [DATA_W-1:0]           ex_hi,
    input  logic [DATA_W-1:0]           ex_lo,
    input  logic [ALUOP_W-1:0]          ex_aluop,
    input  logic [DATA_W-1:0]           ex_mem_addr,
    input  logic [DATA_W-1:0]           ex_reg2,
    input  logic [2*DATA_W-1:0]         hilo_i,
    input  logic [CNT_W-1:0]            cnt_i,
    output logic [LANES*REG_ADDR_W-1:0] mem_wd,
    output logic [LANES-1:0]            mem_wreg,
    output logic [LANES*DATA_W-1:0]     mem_wdata,
    output logic                        mem_whilo,
    output logic [DATA_W-1:0]           mem_hi,
    output logic [DATA_W-1:0]           mem_lo,
    output logic [ALUOP_W-1:0]          mem_aluop,
    output logic [DATA_W-1:0]           mem_mem_addr,
    output logic [DATA_W-1:0]           mem_reg2,
    output logic                        mem_valid,
    output logic [2*DATA_W-1:0]         hilo_o,
    output logic [CNT_W-1:0]            cnt_o,
    output logic [STALL_CNT_W-1:0]      bubble_cnt
);

    if (STAGE < 0 || STAGE > 4) begin : g_bad_stage
        $error("ex_mem_stage_reg: STAGE must be in 0..4");
    end

    stage_ctl_e ctl;
    logic       advance, bubble, clear;
    logic       unused_stall;

    assign ctl          = decode_ctl(flush, stall[STAGE], stall[STAGE+1]);
    assign advance      = (ctl == CTL_ADVANCE);
    assign bubble       = (ctl == CTL_BUBBLE);
    assign clear        = (ctl == CTL_FLUSH);
    assign unused_stall = ^stall;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pipe_lane_reg #(
            .REG_ADDR_W (REG_ADDR_W),
            .DATA_W     (DATA_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .advance (advance),
            .bubble  (bubble),
            .wd_i    (ex_wd[g*REG_ADDR_W +: REG_ADDR_W]),
            .wreg_i  (ex_wreg[g]),
            .wdata_i (ex_wdata[g*DATA_W +: DATA_W]),
            .wd_o    (mem_wd[g*REG_ADDR_W +: REG_ADDR_W]),
            .wreg_o  (mem_wreg[g]),
            .wdata_o (mem_wdata[g*DATA_W +: DATA_W])
        );
    end

    logic                   whilo_q, whilo_d;
    logic [DATA_W-1:0]      hi_q, hi_d, lo_q, lo_d;
    logic [ALUOP_W-1:0]     aluop_q, aluop_d;
    logic [DATA_W-1:0]      addr_q, addr_d, reg2_q, reg2_d;
    logic                   valid_q, valid_d;
    logic [2*DATA_W-1:0]    hilo_q, hilo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // The MADD temporaries keep following EX whenever this stage is held,
    // and are dropped once the instruction finally advances.
    always_comb begin
        whilo_d      = whilo_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        aluop_d      = aluop_q;
        addr_d       = addr_q;
        reg2_d       = reg2_q;
        valid_d      = valid_q;
        hilo_d       = hilo_q;
        cnt_d        = cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        unique case (ctl)
            CTL_FLUSH: begin
                whilo_d      = WRITE_DISABLE;
                hi_d         = '0;
                lo_d         = '0;
                aluop_d      = '0;
                addr_d       = '0;
                reg2_d       = '0;
                valid_d      = 1'b0;
                hilo_d       = '0;
                cnt_d        = '0;
                bubble_cnt_d = '0;
            end
            CTL_BUBBLE: begin
                whilo_d      = WRITE_DISABLE;
                hi_d         = '0;
                lo_d         = '0;
                aluop_d      = '0;
                addr_d       = '0;
                reg2_d       = '0;
                valid_d      = 1'b0;
                hilo_d       = hilo_i;
                cnt_d        = cnt_i;
                bubble_cnt_d = (&bubble_cnt_q) ? bubble_cnt_q
                                               : bubble_cnt_q + STALL_CNT_W'(1);
            end
            CTL_ADVANCE: begin
                whilo_d      = ex_whilo;
                hi_d         = ex_hi;
                lo_d         = ex_lo;
                aluop_d      = ex_aluop;
                addr_d       = ex_mem_addr;
                reg2_d       = ex_reg2;
                valid_d      = 1'b1;
                hilo_d       = '0;
                cnt_d        = '0;
                bubble_cnt_d = '0;
            end
            default: begin
                hilo_d = hilo_i;
                cnt_d  = cnt_i;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            whilo_q      <= WRITE_DISABLE;
            hi_q         <= '0;
            lo_q         <= '0;
            aluop_q      <= '0;
            addr_q       <= '0;
            reg2_q       <= '0;
            valid_q      <= 1'b0;
            hilo_q       <= '0;
            cnt_q        <= '0;
            bubble_cnt_q <= '0;
        end else begin
            whilo_q      <= whilo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            aluop_q      <= aluop_d;
            addr_q       <= addr_d;
            reg2_q       <= reg2_d;
            valid_q      <= valid_d;
            hilo_q       <= hilo_d;
            cnt_q        <= cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign mem_whilo    = whilo_q;
    assign mem_hi       = hi_q;
    assign mem_lo       = lo_q;
    assign mem_aluop    = aluop_q;
    assign mem_mem_addr = addr_q;
    assign mem_reg2     = reg2_q;
    assign mem_valid    = valid_q;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg (2 lanes, 2-bit bubble counter): directed vector
// table followed by random traffic checked against a slot-level model.
module tb_ex_mem_stage_reg;

    localparam int LANES       = 2;
    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 32;
    localparam int ALUOP_W     = 8;
    localparam int CNT_W       = 2;
    localparam int STAGE       = 3;
    localparam int STALL_CNT_W = 2;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [5:0]  stall;
    logic [9:0]  ex_wd, mem_wd;
    logic [1:0]  ex_wreg, mem_wreg;
    logic [63:0] ex_wdata, mem_wdata;
    logic        ex_whilo, mem_whilo;
    logic [31:0] ex_hi, ex_lo, mem_hi, mem_lo;
    logic [7:0]  ex_aluop, mem_aluop;
    logic [31:0] ex_mem_addr, ex_reg2, mem_mem_addr, mem_reg2;
    logic [63:0] hilo_i, hilo_o;
    logic [1:0]  cnt_i, cnt_o;
    logic        mem_valid;
    logic [1:0]  bubble_cnt;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(
        .LANES(LANES), .REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W), .ALUOP_W(ALUOP_W),
        .CNT_W(CNT_W), .STAGE(STAGE), .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o),
        .bubble_cnt(bubble_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // What the MEM slot holds, plus the count of back-to-back bubbles as a plain integer.
    typedef struct {
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic [7:0]  aluop;
        logic [31:0] addr, reg2;
        logic        valid;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        int          bubbles;
    } model_t;

    model_t mdl;

    typedef struct {
        logic        rst, flush;
        logic [5:0]  stall;
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic        e_valid;
        logic [1:0]  e_wreg;
        logic [9:0]  e_wd;
        logic [63:0] e_wdata;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
        logic [1:0]  e_bub;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic f, logic [5:0] s, logic [9:0] wd,
                                logic [1:0] wr, logic [63:0] wdat, logic [63:0] h,
                                logic [1:0] c, logic ev, logic [1:0] ewr, logic [9:0] ewd,
                                logic [63:0] ewdat, logic [63:0] eh, logic [1:0] ec,
                                logic [1:0] eb);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.wd = wd; v.wreg = wr; v.wdata = wdat;
        v.hilo = h; v.cnt = c; v.e_valid = ev; v.e_wreg = ewr; v.e_wd = ewd;
        v.e_wdata = ewdat; v.e_hilo = eh; v.e_cnt = ec; v.e_bub = eb;
        return v;
    endfunction

    task automatic check_field(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slot-level reference: a held stage inserts a NOP unless MEM is also held.
    task automatic model_step();
        model_t nxt;
        logic   mine_held, next_held;
        nxt       = mdl;
        mine_held = stall[STAGE];
        next_held = stall[STAGE+1];
        if (rst || flush) begin
            nxt = '{default: '0};
        end else if (!mine_held) begin
            nxt = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo, hi: ex_hi,
                    lo: ex_lo, aluop: ex_aluop, addr: ex_mem_addr, reg2: ex_reg2,
                    valid: 1'b1, hilo: 64'd0, cnt: 2'd0, bubbles: 0};
        end else if (!next_held) begin
            nxt = '{wd: 10'd0, wreg: 2'd0, wdata: 64'd0, whilo: 1'b0, hi: 32'd0, lo: 32'd0,
                    aluop: 8'd0, addr: 32'd0, reg2: 32'd0, valid: 1'b0, hilo: hilo_i,
                    cnt: cnt_i, bubbles: mdl.bubbles + 1};
        end else begin
            nxt.hilo = hilo_i;
            nxt.cnt  = cnt_i;
        end
        mdl = nxt;
    endtask

    task automatic checkOutput();
        int sat;
        sat = (mdl.bubbles > 3) ? 3 : mdl.bubbles;
        check_field("mem_wd",       64'(mem_wd),       64'(mdl.wd));
        check_field("mem_wreg",     64'(mem_wreg),     64'(mdl.wreg));
        check_field("mem_wdata",    mem_wdata,         mdl.wdata);
        check_field("mem_whilo",    64'(mem_whilo),    64'(mdl.whilo));
        check_field("mem_hi",       64'(mem_hi),       64'(mdl.hi));
        check_field("mem_lo",       64'(mem_lo),       64'(mdl.lo));
        check_field("mem_aluop",    64'(mem_aluop),    64'(mdl.aluop));
        check_field("mem_mem_addr", 64'(mem_mem_addr), 64'(mdl.addr));
        check_field("mem_reg2",     64'(mem_reg2),     64'(mdl.reg2));
        check_field("mem_valid",    64'(mem_valid),    64'(mdl.valid));
        check_field("hilo_o",       hilo_o,            mdl.hilo);
        check_field("cnt_o",        64'(cnt_o),        64'(mdl.cnt));
        check_field("bubble_cnt",   64'(bubble_cnt),   64'(sat));
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check_field({tag, ".valid"},  64'(mem_valid),  64'(v.e_valid));
        check_field({tag, ".wreg"},   64'(mem_wreg),   64'(v.e_wreg));
        check_field({tag, ".wd"},     64'(mem_wd),     64'(v.e_wd));
        check_field({tag, ".wdata"},  mem_wdata,       v.e_wdata);
        check_field({tag, ".hilo"},   hilo_o,          v.e_hilo);
        check_field({tag, ".cnt"},    64'(cnt_o),      64'(v.e_cnt));
        check_field({tag, ".bubble"}, 64'(bubble_cnt), 64'(v.e_bub));
    endtask

    // Inputs are driven 1ns after a rising edge; outputs are sampled 1ns after the next one.
    task automatic applyStimulus();
        @(posedge clk);
        model_step();
        #1;
    endtask

    localparam logic [5:0] S_ADV  = 6'b000000;
    localparam logic [5:0] S_BUB  = 6'b001111;
    localparam logic [5:0] S_HOLD = 6'b011111;

    initial begin
        logic [9:0]  wd_a, wd_b;
        logic [63:0] wdata_a, wdata_b, h1;
        wd_a    = {5'd3, 5'd7};
        wd_b    = {5'd9, 5'd1};
        wdata_a = {32'hA5A5_0001, 32'h0000_00FF};
        wdata_b = {32'h1234_5678, 32'h8765_4321};
        h1      = 64'h1_0000_0002;
        mdl     = '{default: '0};

        vecs.push_back(mk(1,0,S_ADV, wd_a,2'b11,wdata_a,64'hDEAD,2'd3, 0,2'b00,10'd0,64'd0,64'd0,2'd0,2'd0));
        vecs.push_back(mk(1,0,S_ADV, wd_a,2'b11,wdata_a,64'hDEAD,2'd3, 0,2'b00,10'd0,64'd0,64'd0,2'd0,2'd0));
        vecs.push_back(mk(0,0,S_ADV, wd_a,2'b11,wdata_a,64'd0,   2'd0, 1,2'b11,wd_a, wdata_a,64'd0,2'd0,2'd0));
        vecs.push_back(mk(0,0,S_BUB, wd_a,2'b11,wdata_a,h1,      2'd1, 0,2'b00,10'd0,64'd0,h1,2'd1,2'd1));
        vecs.push_back(mk(0,0,S_BUB, wd_a,2'b11,wdata_a,h1,      2'd2, 0,2'b00,10'd0,64'd0,h1,2'd2,2'd2));
        vecs.push_back(mk(0,0,S_BUB, wd_a,2'b11,wdata_a,h1,      2'd2, 0,2'b00,10'd0,64'd0,h1,2'd2,2'd3));
        vecs.push_back(mk(0,0,S_ADV, wd_b,2'b01,wdata_b,64'd5,   2'd3, 1,2'b01,wd_b, wdata_b,64'd0,2'd0,2'd0));
        vecs.push_back(mk(0,0,S_HOLD,wd_a,2'b11,wdata_a,64'h77,  2'd1, 1,2'b01,wd_b, wdata_b,64'h77,2'd1,2'd0));
        vecs.push_back(mk(0,0,S_HOLD,wd_a,2'b11,wdata_a,64'h88,  2'd2, 1,2'b01,wd_b, wdata_b,64'h88,2'd2,2'd0));
        vecs.push_back(mk(0,0,S_BUB, wd_a,2'b11,wdata_a,64'd1,   2'd1, 0,2'b00,10'd0,64'd0,64'd1,2'd1,2'd1));
        vecs.push_back(mk(0,0,S_HOLD,wd_a,2'b11,wdata_a,64'd2,   2'd0, 0,2'b00,10'd0,64'd0,64'd2,2'd0,2'd1));
        vecs.push_back(mk(0,1,S_BUB, wd_a,2'b11,wdata_a,64'd9,   2'd2, 0,2'b00,10'd0,64'd0,64'd0,2'd0,2'd0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0,0,S_BUB,wd_a,2'b11,wdata_a,64'hF,2'd1, 0,2'b00,10'd0,64'd0,64'hF,2'd1,
                              (k < 2) ? 2'(k + 1) : 2'd3));
        vecs.push_back(mk(1,0,S_BUB, wd_a,2'b11,wdata_a,64'hF,   2'd1, 0,2'b00,10'd0,64'd0,64'd0,2'd0,2'd0));
        vecs.push_back(mk(0,0,S_ADV, wd_a,2'b11,wdata_a,64'd0,   2'd0, 1,2'b11,wd_a, wdata_a,64'd0,2'd0,2'd0));
        vecs.push_back(mk(0,1,S_ADV, wd_a,2'b11,wdata_a,64'd0,   2'd0, 0,2'b00,10'd0,64'd0,64'd0,2'd0,2'd0));

        rst = 1'b1; flush = 1'b0; stall = '0;
        ex_wd = '0; ex_wreg = '0; ex_wdata = '0; hilo_i = '0; cnt_i = '0;
        ex_whilo = 1'b1; ex_hi = 32'h1111_2222; ex_lo = 32'h3333_4444;
        ex_aluop = 8'h21; ex_mem_addr = 32'h8000_0040; ex_reg2 = 32'hCAFE_F00D;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; flush = vecs[i].flush; stall = vecs[i].stall;
            ex_wd = vecs[i].wd; ex_wreg = vecs[i].wreg; ex_wdata = vecs[i].wdata;
            hilo_i = vecs[i].hilo; cnt_i = vecs[i].cnt;
            applyStimulus();
            checkVector(i, vecs[i]);
            checkOutput();
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 31) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            stall       = 6'($urandom);
            ex_wd       = 10'($urandom);
            ex_wreg     = 2'($urandom);
            ex_wdata    = {$urandom, $urandom};
            ex_whilo    = 1'($urandom);
            ex_hi       = $urandom;
            ex_lo       = $urandom;
            ex_aluop    = 8'($urandom);
            ex_mem_addr = $urandom;
            ex_reg2     = $urandom;
            hilo_i      = {$urandom, $urandom};
            cnt_i       = 2'($urandom);
            applyStimulus();
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline register for the MIPS32 core.
- Generalised to N write lanes and configurable widths, with load/store operand carry and a pipeline flush input.
- Carries multi-cycle MADD/MSUB temporaries (hilo, cnt) across stalls, and adds valid tracking plus a saturating bubble counter for perf debug.
- Sits between the EX stage and the MEM stage; driven by the CTRL stall vector and the exception flush line.

Parameters:
- LANES, 1, number of parallel register-write lanes (dual issue = 2)
- REG_ADDR_W, 5, GPR address width per lane
- DATA_W, 32, datapath width; hilo temporary is 2*DATA_W
- ALUOP_W, 8, ALU/memory op code width
- CNT_W, 2, multi-cycle step counter width
- STAGE, 3, index of this stage in stall[5:0]; legal range 0..4
- STALL_CNT_W, 8, bubble counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high (`RstEnable)
- stall  in  6  CTRL stall vector; bit STAGE = this stage held, bit STAGE+1 = next stage held
- flush  in  1  exception/pipeline flush
- ex_wd  in  LANES*REG_ADDR_W  destination register per lane
- ex_wreg  in  LANES  write enable per lane
- ex_wdata  in  LANES*DATA_W  result per lane
- ex_whilo  in  1  HI/LO write enable
- ex_hi, ex_lo  in  DATA_W each  HI/LO values
- ex_aluop  in  ALUOP_W  op code forwarded to MEM
- ex_mem_addr  in  DATA_W  load/store effective address
- ex_reg2  in  DATA_W  store data
- hilo_i  in  2*DATA_W  multi-cycle temporary from EX
- cnt_i  in  CNT_W  multi-cycle step from EX
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as inputs  registered copies of the EX fields
- mem_valid  out  1  MEM holds a real instruction
- hilo_o  out  2*DATA_W  temporary fed back to EX
- cnt_o  out  CNT_W  step fed back to EX
- bubble_cnt  out  STALL_CNT_W  consecutive bubble cycles, saturating

Behaviour:
- All updates occur on posedge clk. Latency is one cycle. Priority per cycle: rst > flush > bubble > advance > hold.
- Reset state:
  - all mem_* fields = 0 (wd = `NOPRegAddr, wreg/whilo = `WriteDisable)
  - mem_aluop = 0 (NOP), mem_valid = 0, hilo_o = 0, cnt_o = 0, bubble_cnt = 0
- Flush:
  - clears all outputs to reset values, including hilo_o/cnt_o, so an aborted MADD restarts.
  - bubble_cnt = 0.
  - Overrides any stall pattern.
- Bubble (stall[STAGE]=1, stall[STAGE+1]=0):
  - mem_* fields get NOP values and mem_valid = 0.
  - hilo_o <= hilo_i, cnt_o <= cnt_i.
  - bubble_cnt increments, saturating at 2^STALL_CNT_W-1.
- Advance (stall[STAGE]=0):
  - mem_* fields <= ex_*, all lanes together; mem_valid = 1.
  - hilo_o = 0, cnt_o = 0, bubble_cnt = 0.
- Hold (stall[STAGE]=1, stall[STAGE+1]=1):
  - mem_* fields and mem_valid are unchanged; bubble_cnt is unchanged.
  - hilo_o <= hilo_i, cnt_o <= cnt_i, so the temporaries keep tracking EX.
- Lanes are independent slices of identical logic. A lane with wreg=0 still latches its wd/wdata.
- No combinational input-to-output paths.
- STAGE outside 0..4 is a configuration error. Guard it with an elaboration-time check.

Decomposition:
- Shared defines.vh supplies `RstEnable, `Stop/`NoStop, `WriteDisable, `NOPRegAddr, `ZeroWord and the NOP aluop constant.
- Add one new constant there: `STALL_W = 6.
- Sub-module pipe_lane_reg: holds one lane's {wd, wreg, wdata} with advance/bubble/hold/clear controls. The top instantiates LANES copies in a generate loop.
- Control decode (flush/bubble/advance/hold) and the hilo/cnt/bubble_cnt logic live in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero ex_* inputs -> every output 0, mem_valid=0, on the first edge.
- Advance, LANES=2: stall=0, ex_wd={5'd3,5'd7}, ex_wdata={32'hA5A5_0001,32'h0000_00FF}, wreg=2'b11 -> next cycle mem_* match, mem_valid=1, hilo_o=0, cnt_o=0.
- MADD bubble: stall=6'b001111 for 3 cycles, hilo_i=64'h1_0000_0002, cnt_i=1 then 2 -> mem_wreg=0, mem_valid=0, hilo_o/cnt_o track one cycle behind, bubble_cnt=1,2,3. Then stall=0 -> cnt_o=0, bubble_cnt=0.
- Hold: load an instruction, then stall=6'b011111 -> mem_wdata and mem_valid frozen, bubble_cnt unchanged, hilo_o still follows hilo_i.
- Flush precedence: flush=1 with stall=6'b001111 and cnt_i=2 -> all outputs cleared, cnt_o=0, bubble_cnt=0.
- Saturation: STALL_CNT_W=2, bubble held 6 cycles -> bubble_cnt sticks at 3. Then rst asserted mid-bubble -> all outputs 0 on the next edge.
